htg_ad9213_mmcm_supervisor: RTL
===============================

Name: htg_ad9213_mmcm_supervisor

Overview:
- Sequences and supervises the AD9213 capture-clock MMCM.
- Drives the MMCM reset, qualifies LOCKED, and holds downstream capture logic in reset until the clock is stable.
- Detects lock loss and retries, and exposes sticky status for software registers.
- Runs on a free-running board clock, never on the MMCM output.

Parameters:
RST_CYCLES, 16, cycles mmcm_rst is held high per reset attempt (min 1)
LOCK_STABLE_CYCLES, 64, consecutive synced-locked cycles required to declare lock
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry
DS_RST_CYCLES, 32, cycles downstream reset stays high after lock is qualified
MAX_RETRIES, 7, consecutive timeouts before FAULT (optional feature only)
CNT_W, 8, width of relock_count

Ports:
clk  in  1  free-running board clock (not MMCM output)
rst  in  1  synchronous, active-high reset
enable  in  1  0 forces and holds RESET state
soft_reset  in  1  single-cycle request to restart sequence
clear_status  in  1  clears timeout_err and relock_count
mmcm_locked  in  1  MMCM LOCKED, asynchronous to clk
mmcm_rst  out  1  to MMCM RST
ds_rst  out  1  downstream capture reset
ready  out  1  clock qualified and downstream released
timeout_err  out  1  sticky: a WAIT_LOCK timeout occurred
fault  out  1  retry limit reached (optional feature only, else 0)
relock_count  out  CNT_W  saturating count of lock losses in RUN/DS_RST

Behaviour:
- Reset: state=RESET, mmcm_rst=1, ds_rst=1, ready=0, timeout_err=0, fault=0, relock_count=0, all counters 0.
- Sync: mmcm_locked passes through 2 flops to give locked_s (2-cycle latency). All decisions use locked_s only.
- All outputs are registered and decoded from state.
- RESET:
  - mmcm_rst=1, ds_rst=1, ready=0.
  - After RST_CYCLES cycles with enable=1, go to WAIT_LOCK.
  - enable=0 holds the counter at 0.
- WAIT_LOCK:
  - mmcm_rst=0.
  - stable_cnt increments while locked_s=1 and clears to 0 when locked_s=0.
  - stable_cnt reaching LOCK_STABLE_CYCLES: go to DS_RST and clear the retry count.
  - timeout counter reaching LOCK_TIMEOUT_CYCLES first: set timeout_err, increment retry count, go to RESET.
- DS_RST:
  - ds_rst=1, ready=0.
  - After DS_RST_CYCLES, go to RUN.
  - locked_s=0 at any point: go to LOST.
- RUN:
  - ds_rst=0, ready=1.
  - locked_s=0: go to LOST. ready falls the cycle after locked_s is sampled low.
- LOST (1 cycle):
  - relock_count += 1, saturating at 2^CNT_W-1.
  - ds_rst=1, ready=0, then go to RESET.
- Priority, highest first: rst > enable=0 > soft_reset > clear_status > normal transitions.
- soft_reset in any state: go to RESET next cycle, clear the retry count, no relock_count increment, even if lock is lost the same cycle.
- clear_status coinciding with a LOST increment: clear wins, count becomes 0.
- Counter width: each counter is sized by $clog2 of its parameter, plus 1 bit. Counters must never wrap.
- A glitch on mmcm_locked shorter than 1 clk may be missed; this is acceptable.

Optional Feature:
- Macro HTG_AD9213_MMCM_RETRY_LIMIT_EN.
- Defined:
  - A timeout that brings the retry count to MAX_RETRIES enters FAULT instead of RESET.
  - In FAULT: mmcm_rst=1, ds_rst=1, ready=0, fault=1.
  - FAULT exits only via rst or soft_reset (to RESET, fault cleared).
- Undefined:
  - Unlimited retries, no FAULT state, fault tied 0, no retry counter logic.

Decomposition:
- Package htg_ad9213_mmcm_pkg holds:
  - state enum (RESET, WAIT_LOCK, DS_RST, RUN, LOST, FAULT)
  - parameter defaults
  - counter-width helper constants
- Sub-module htg_ad9213_lock_filter contains the 2-flop synchronizer and the stable-lock counter.
  - Outputs: locked_s, lock_qualified.
  - Input: clr.

Test Plan:
1. rst released, mmcm_locked=1 constant -> mmcm_rst high exactly 16 cycles; ready and ds_rst-low same cycle, 112..116 cycles after release; relock_count=0.
2. In RUN, drop mmcm_locked for 5 cycles -> ready low within 3 cycles; mmcm_rst re-pulsed 16 cycles; relock_count=1; ready returns after relock.
3. mmcm_locked never asserts, LOCK_TIMEOUT_CYCLES=100 -> timeout_err set at ~cycle 116; mmcm_rst re-pulses every ~116 cycles; ready stays 0.
4. Same as 3 with HTG_AD9213_MMCM_RETRY_LIMIT_EN, MAX_RETRIES=3 -> fault=1 after 3rd timeout and mmcm_rst held high; soft_reset pulse clears fault and sequence restarts.
5. locked toggling every 40 cycles in WAIT_LOCK (LOCK_STABLE_CYCLES=64) -> never reaches DS_RST; timeout path taken.
6. soft_reset and lock loss in the same RUN cycle -> RESET entered, relock_count unchanged. clear_status together with a LOST increment -> relock_count=0.

Source files
------------

// File: rtl/htg_ad9213_mmcm_pkg.sv
// rtl/htg_ad9213_mmcm_pkg.sv - state encoding, parameter defaults and counter sizing for the MMCM supervisor
package htg_ad9213_mmcm_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    DS_RST,
    RUN,
    LOST,
    FAULT
  } state_t;

  localparam int unsigned DEF_RST_CYCLES          = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_DS_RST_CYCLES       = 32;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_CNT_W               = 8;

  // One spare bit above the terminal value so no counter can wrap.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/htg_ad9213_lock_filter.sv
// rtl/htg_ad9213_lock_filter.sv - synchronises MMCM LOCKED and qualifies it over a run of stable cycles
module htg_ad9213_lock_filter
  import htg_ad9213_mmcm_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic mmcm_locked,
  output logic locked_s,
  output logic lock_qualified
);

  localparam int unsigned W = cnt_width(LOCK_STABLE_CYCLES);
  localparam logic [W-1:0] TARGET = W'(LOCK_STABLE_CYCLES - 1);

  logic         meta;
  logic [W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      meta     <= mmcm_locked;
      locked_s <= meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr || !locked_s) begin
      stable_cnt <= '0;
    end else if (stable_cnt != TARGET) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign lock_qualified = locked_s && (stable_cnt == TARGET);

endmodule

// File: rtl/htg_ad9213_mmcm_supervisor.sv
// rtl/htg_ad9213_mmcm_supervisor.sv - AD9213 capture MMCM sequencer/supervisor
// HTG_AD9213_MMCM_RETRY_LIMIT_EN adds a FAULT state after MAX_RETRIES consecutive lock timeouts.
module htg_ad9213_mmcm_supervisor
  import htg_ad9213_mmcm_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned DS_RST_CYCLES       = DEF_DS_RST_CYCLES,
`ifdef HTG_AD9213_MMCM_RETRY_LIMIT_EN
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
`endif
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             soft_reset,
  input  logic             clear_status,
  input  logic             mmcm_locked,
  output logic             mmcm_rst,
  output logic             ds_rst,
  output logic             ready,
  output logic             timeout_err,
  output logic             fault,
  output logic [CNT_W-1:0] relock_count
);

  localparam int unsigned RST_W = cnt_width(RST_CYCLES);
  localparam int unsigned TO_W  = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned DS_W  = cnt_width(DS_RST_CYCLES);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [DS_W-1:0]  DS_LAST  = DS_W'(DS_RST_CYCLES - 1);

  state_t            state, next_state;
  logic              locked_s, lock_qualified;
  logic              in_wait, timeout, timeout_take, restart;
  logic              mmcm_rst_d, ds_rst_d, ready_d;
  logic [RST_W-1:0]  rst_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DS_W-1:0]   ds_cnt;

  htg_ad9213_lock_filter #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_filter (
    .clk            (clk),
    .rst            (rst),
    .clr            (!in_wait),
    .mmcm_locked    (mmcm_locked),
    .locked_s       (locked_s),
    .lock_qualified (lock_qualified)
  );

  assign in_wait      = (state == WAIT_LOCK);
  assign timeout      = in_wait && (to_cnt == TO_LAST);
  assign timeout_take = timeout && enable && !soft_reset && !lock_qualified;

`ifdef HTG_AD9213_MMCM_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_hit;

  assign retry_hit = (retry_cnt >= RETRY_LAST);

  always_ff @(posedge clk) begin
    if (rst || (enable && soft_reset) || (in_wait && enable && lock_qualified)) begin
      retry_cnt <= '0;
    end else if (timeout_take) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    next_state = state;
    // FAULT is only left through soft_reset, even with enable low.
    if (state == FAULT) begin
      next_state = soft_reset ? RESET : FAULT;
    end else if (!enable || soft_reset) begin
      next_state = RESET;
    end else begin
      case (state)
        RESET:     if (rst_cnt == RST_LAST) next_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_qualified) begin
            next_state = DS_RST;
          end else if (timeout) begin
`ifdef HTG_AD9213_MMCM_RETRY_LIMIT_EN
            next_state = retry_hit ? FAULT : RESET;
`else
            next_state = RESET;
`endif
          end
        end
        DS_RST: begin
          if (!locked_s)                next_state = LOST;
          else if (ds_cnt == DS_LAST)   next_state = RUN;
        end
        RUN:       if (!locked_s) next_state = LOST;
        LOST:      next_state = RESET;
        default:   next_state = RESET;
      endcase
    end
  end

  always_comb begin
    mmcm_rst_d = (next_state == RESET) || (next_state == FAULT);
    ds_rst_d   = (next_state != RUN);
    ready_d    = (next_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET;
      mmcm_rst <= 1'b1;
      ds_rst   <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= next_state;
      mmcm_rst <= mmcm_rst_d;
      ds_rst   <= ds_rst_d;
      ready    <= ready_d;
    end
  end

`ifdef HTG_AD9213_MMCM_RETRY_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) fault <= 1'b0;
    else     fault <= (next_state == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

  // Phase counters restart on every state change so each dwell is measured from entry.
  assign restart = (next_state != state) || soft_reset || !enable;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
      ds_cnt  <= '0;
    end else begin
      if (state == RESET)     rst_cnt <= rst_cnt + 1'b1;
      if (state == WAIT_LOCK) to_cnt  <= to_cnt + 1'b1;
      if (state == DS_RST)    ds_cnt  <= ds_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_status) begin
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      if (timeout_take) timeout_err <= 1'b1;
      if ((next_state == LOST) && (relock_count != {CNT_W{1'b1}}))
        relock_count <= relock_count + 1'b1;
    end
  end

endmodule
